// File: rtl/disparity_readout.sv
// Disparity BRAM readout: raster-order address sequencer, read-latency
// tag pipeline and skid FIFO feeding a valid/ready 8-bit pixel stream.
module disparity_readout #(
  parameter int H_PIXELS    = 240,
  parameter int V_PIXELS    = 320,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SCALE_SHIFT = 0
) (
  input  logic        clk_100mhz,
  input  logic        sys_rst,
  input  logic        frame_done_in,
  output logic        reading_out,
  output logic [16:0] ssd_addr_out,
  input  logic [7:0]  ssd_dout_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic [7:0]  m_hcount,
  output logic [8:0]  m_vcount,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_done_out,
  output logic        overrun_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int LAST = H_PIXELS * V_PIXELS - 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW   = 8 + SCALE_SHIFT;
  localparam int EW   = 27;

  logic [1:0]  state;
  logic [7:0]  x;
  logic [8:0]  y;

  logic [RD_LATENCY-1:0]       pv;
  logic [RD_LATENCY-1:0][7:0]  px;
  logic [RD_LATENCY-1:0][8:0]  py;

  logic [FIFO_DEPTH-1:0][EW-1:0] mem;
  logic [FIFO_DEPTH-1:0][EW-1:0] nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] wr;

  int          inflight;
  logic        issue;
  logic        push;
  logic        pop;
  logic        drain_done;
  logic [SW-1:0] wide;
  logic [7:0]  pix;
  logic        t_sof;
  logic        t_eol;
  logic [EW-1:0] entry;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight += int'(pv[i]);
  end

  // A pop in the same cycle is deliberately not credited to the issue check.
  assign issue = (state == READ) &&
                 (inflight + int'(cnt) < FIFO_DEPTH);
  assign push  = pv[RD_LATENCY-1];
  assign pop   = m_valid && m_ready;

  assign drain_done = (state == DRAIN) && (inflight == 0) &&
                      ((cnt == '0) || ((cnt == CW'(1)) && pop));

  assign wide  = SW'(ssd_dout_in) << SCALE_SHIFT;
  assign pix   = (wide > SW'(255)) ? 8'hff : wide[7:0];
  assign t_sof = (px[RD_LATENCY-1] == 8'd0) &&
                 (py[RD_LATENCY-1] == 9'd0);
  assign t_eol = (px[RD_LATENCY-1] == 8'(H_PIXELS - 1));
  assign entry = {t_sof, t_eol, py[RD_LATENCY-1],
                  px[RD_LATENCY-1], pix};

  assign m_data   = mem[0][7:0];
  assign m_hcount = mem[0][15:8];
  assign m_vcount = mem[0][24:16];
  assign m_eol    = mem[0][25];
  assign m_sof    = mem[0][26];

  always_comb begin
    nxt = mem;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++)
        nxt[i] = mem[i+1];
      nxt[FIFO_DEPTH-1] = '0;
    end
    wr = AW'(cnt - CW'(pop));
    if (push)
      nxt[wr] = entry;
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (!push && pop)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      mem     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else begin
      mem     <= nxt;
      cnt     <= cnt_nxt;
      m_valid <= (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      pv <= '0;
      px <= '0;
      py <= '0;
    end else begin
      pv[0] <= issue;
      px[0] <= x;
      py[0] <= y;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      reading_out    <= 1'b0;
      ssd_addr_out   <= '0;
      x              <= '0;
      y              <= '0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      overrun_out    <= frame_done_in && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (frame_done_in) begin
            state        <= READ;
            reading_out  <= 1'b1;
            ssd_addr_out <= '0;
            x            <= '0;
            y            <= '0;
          end
        end
        READ: begin
          if (issue) begin
            if (ssd_addr_out == 17'(LAST)) begin
              state <= DRAIN;
            end else begin
              ssd_addr_out <= ssd_addr_out + 17'd1;
              if (x == 8'(H_PIXELS - 1)) begin
                x <= '0;
                y <= y + 9'd1;
              end else begin
                x <= x + 8'd1;
              end
            end
          end
        end
        DRAIN: begin
          // reading_out stays high until the stream is fully drained
          if (drain_done) begin
            state          <= IDLE;
            reading_out    <= 1'b0;
            frame_done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_readout.sv
// Bench for disparity_readout: small-frame raster checks plus a
// scaled instance driven from a vector table.
module tb_disparity_readout;

  localparam int H = 16;
  localparam int V = 20;
  localparam int N = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fdi;
  logic        rd;
  logic [16:0] addr;
  logic [7:0]  dout;
  logic [7:0]  b1;
  logic        mv;
  logic        mr;
  logic [7:0]  md;
  logic [7:0]  mh;
  logic [8:0]  mvc;
  logic        sof;
  logic        eol;
  logic        fdo;
  logic        ovr;

  disparity_readout #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk_100mhz(clk), .sys_rst(rst), .frame_done_in(fdi),
    .reading_out(rd), .ssd_addr_out(addr), .ssd_dout_in(dout),
    .m_valid(mv), .m_ready(mr), .m_data(md), .m_hcount(mh),
    .m_vcount(mvc), .m_sof(sof), .m_eol(eol),
    .frame_done_out(fdo), .overrun_out(ovr)
  );

  // BRAM model: 2-cycle latency, content = addr mod 256
  always @(posedge clk) begin
    b1   <= addr[7:0];
    dout <= b1;
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  logic        s_fdi;
  logic        s_rd;
  logic [16:0] s_addr;
  logic [7:0]  s_dout;
  logic [7:0]  s_b1;
  logic        s_mv;
  logic        s_mr;
  logic [7:0]  s_md;
  logic [7:0]  s_mh;
  logic [8:0]  s_mvc;
  logic        s_sof;
  logic        s_eol;
  logic        s_fdo;
  logic        s_ovr;

  disparity_readout #(.H_PIXELS(8), .V_PIXELS(1),
                      .SCALE_SHIFT(2)) sdut (
    .clk_100mhz(clk), .sys_rst(rst), .frame_done_in(s_fdi),
    .reading_out(s_rd), .ssd_addr_out(s_addr),
    .ssd_dout_in(s_dout), .m_valid(s_mv), .m_ready(s_mr),
    .m_data(s_md), .m_hcount(s_mh), .m_vcount(s_mvc),
    .m_sof(s_sof), .m_eol(s_eol),
    .frame_done_out(s_fdo), .overrun_out(s_ovr)
  );

  always @(posedge clk) begin
    s_b1   <= tbl[s_addr[2:0]].din;
    s_dout <= s_b1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc_no, exp_n, first_valid, last_acc, done_at;
  int n_done, n_ovr, gaps, addr_c1, ovr_a, ovr_b, rmode;
  bit in_frame, hold_v;
  logic [27:0] hold_val;

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    int ex;
    int ey;
    @(negedge clk);
    cyc_no++;
    if (cyc_no == 1) addr_c1 = int'(addr);
    if (mv && first_valid < 0) first_valid = cyc_no;
    if (hold_v)
      check("stall_hold", {mv, md, mh, mvc, sof, eol}, hold_val);
    if (rmode == 0 && in_frame && exp_n > 0 && exp_n < N && !mv)
      gaps++;
    if (mv && mr) begin
      if (exp_n >= N) begin
        check("extra_beat", exp_n, N - 1);
      end else begin
        ex = exp_n % H;
        ey = exp_n / H;
        check("beat_data", md, exp_n % 256);
        check("beat_xy", {mh, mvc}, {ex[7:0], ey[8:0]});
        check("beat_flags", {sof, eol},
              {exp_n == 0, ex == H - 1});
      end
      last_acc = cyc_no;
      exp_n++;
    end
    hold_v   = mv && !mr;
    hold_val = {mv, md, mh, mvc, sof, eol};
    if (fdo) begin
      n_done++;
      done_at = cyc_no;
    end
    if (ovr) n_ovr++;
    @(posedge clk);
    #1;
    fdi = (cyc_no + 1 == ovr_a) || (cyc_no + 1 == ovr_b);
    if (rmode == 0) mr = 1'b1;
    else if (rmode == 1) mr = 1'b0;
    else mr = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(int mode);
    exp_n = 0; gaps = 0; first_valid = -1; last_acc = -1;
    done_at = -1; n_done = 0; n_ovr = 0; hold_v = 0;
    in_frame = 1; rmode = mode; cyc_no = -1;
    mr = (mode != 1);
    fdi = 1'b1;
    cyc();
  endtask

  task automatic finish_frame(int exp_ovr);
    int k;
    k = 0;
    while (n_done == 0 && k < 20 * N) begin
      cyc();
      k++;
    end
    check("frame_done_seen", n_done, 1);
    check("beat_count", exp_n, N);
    check("done_lag", done_at - last_acc, 1);
    check("addr_cycle1", addr_c1, 0);
    repeat (10) cyc();
    check("reading_low", rd, 0);
    check("no_restart", n_done * 1000 + exp_n, 1000 + N);
    check("overruns", n_ovr, exp_ovr);
    in_frame = 0;
  endtask

  logic [7:0] got [8];
  int k2;
  int s_done;

  initial begin
    tbl[0] = '{8'd0,   8'd0};
    tbl[1] = '{8'd1,   8'd4};
    tbl[2] = '{8'd63,  8'd252};
    tbl[3] = '{8'd64,  8'd255};
    tbl[4] = '{8'd100, 8'd255};
    tbl[5] = '{8'd255, 8'd255};
    tbl[6] = '{8'd32,  8'd128};
    tbl[7] = '{8'd50,  8'd200};
    rst = 1'b1; fdi = 1'b0; mr = 1'b1;
    s_fdi = 1'b0; s_mr = 1'b1;
    rmode = 0; ovr_a = -100; ovr_b = -100;
    in_frame = 0; hold_v = 0; cyc_no = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {rd, addr, mv, md, mh, mvc, sof, eol, fdo, ovr}, '0);
    rst = 1'b0;
    repeat (3) cyc();

    // full frame, ready held high
    start_frame(0);
    finish_frame(0);
    check("first_valid_lat", first_valid, 4);
    check("no_gaps", gaps, 0);

    // stall at start, then release
    start_frame(1);
    repeat (12) cyc();
    check("stall_addr", addr, 4);
    check("stall_head", {mv, md, sof}, {1'b1, 8'd0, 1'b1});
    repeat (8) cyc();
    check("stall_addr_frozen", addr, 4);
    rmode = 0;
    finish_frame(0);
    check("release_no_gaps", gaps, 0);

    // random backpressure
    start_frame(2);
    finish_frame(0);

    // overrun mid-READ and on the DRAIN exit cycle
    ovr_a = 20;
    ovr_b = N + 3;
    start_frame(0);
    finish_frame(2);
    check("last_beat_cycle", last_acc, N + 3);
    ovr_a = -100;
    ovr_b = -100;

    // async reset mid-frame
    start_frame(0);
    k2 = 0;
    while (exp_n < 100 && k2 < 10 * N) begin
      cyc();
      k2++;
    end
    check("reached_beat_100", exp_n, 100);
    rst = 1'b1;
    #1;
    check("midframe_reset",
          {rd, addr, mv, md, mh, mvc, sof, eol, fdo, ovr}, '0);
    in_frame = 0;
    hold_v = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cyc();
    start_frame(0);
    finish_frame(0);
    check("restart_first_valid", first_valid, 4);

    // scaled instance, table-driven
    for (int i = 0; i < 8; i++) got[i] = '0;
    k2 = 0;
    s_done = 0;
    s_fdi = 1'b1;
    @(posedge clk);
    #1;
    s_fdi = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_mv) begin
        if (k2 < 8) got[k2] = s_md;
        k2++;
      end
      if (s_fdo) s_done++;
      @(posedge clk);
      #1;
    end
    check("scale_beats", k2, 8);
    check("scale_done", s_done, 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("scale_%0d", i), got[i], tbl[i].exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/disparity_readout.md
Name: disparity_readout

Overview:
- Drains the 320x240 disparity result BRAM after the stereo matcher finishes a frame.
- Drives the BRAM's external read port: `reading`, `external_ssd_addr` and `ssd_dout`.
- Absorbs the 2-cycle BRAM read latency and emits a raster-ordered 8-bit grayscale pixel stream with valid/ready backpressure for display or host readout.
- Sits between the matcher's `new_frame_out` and the downstream video/UART consumer.

Parameters:
- H_PIXELS, 240, pixels per row (x extent); address = y*H_PIXELS + x.
- V_PIXELS, 320, rows per frame (y extent).
- RD_LATENCY, 2, cycles from address presented to data valid on ssd_dout_in.
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LATENCY+1.
- SCALE_SHIFT, 0, left shift applied to disparity before saturation to 8 bits.

Ports:
- clk_100mhz  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- frame_done_in  in  1  one-cycle pulse from matcher new_frame_out; starts a readout.
- reading_out  out  1  to matcher `reading`; high for the entire readout.
- ssd_addr_out  out  17  to matcher `external_ssd_addr`; registered.
- ssd_dout_in  in  8  from matcher `ssd_dout`.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accepts the beat when m_valid & m_ready.
- m_data  out  8  scaled disparity pixel.
- m_hcount  out  8  x of the beat, 0..H_PIXELS-1.
- m_vcount  out  9  y of the beat, 0..V_PIXELS-1.
- m_sof  out  1  high on the beat (0,0).
- m_eol  out  1  high on the beat x = H_PIXELS-1.
- frame_done_out  out  1  one-cycle pulse after the last beat is accepted.
- overrun_out  out  1  one-cycle pulse when frame_done_in arrives while not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including ssd_addr_out. FIFO emptied, in-flight pipeline cleared, coordinate counters at 0.
- States: IDLE, READ, DRAIN.
- IDLE: on frame_done_in go to READ, set reading_out=1, ssd_addr_out=0, issue x=0, y=0.
- READ issue rule: a read issues in a cycle when in_flight + fifo_count < FIFO_DEPTH.
  - in_flight = reads issued but not yet returned.
  - A same-cycle pop is not credited.
- On issue: the address and coordinate tag enter an RD_LATENCY-stage valid/tag shift register.
  - Address/x/y advance next cycle; x wraps at H_PIXELS-1 to 0 with y+1.
- When not issuing, ssd_addr_out holds its value.
- A read issued at cycle t (ssd_addr_out = A during t) returns valid data on ssd_dout_in in cycle t+RD_LATENCY. It is written into the FIFO at the end of that cycle.
- Issuing address H_PIXELS*V_PIXELS-1 moves the state to DRAIN; no further issues.
- DRAIN: when in_flight = 0, the FIFO is empty, and no beat is pending, go to IDLE.
  - Same edge: reading_out=0 and frame_done_out pulses for 1 cycle.
- reading_out stays high through DRAIN, so the matcher cannot write mid-readout.
- Throughput: with m_ready held high, one beat per cycle sustained.
  - First m_valid appears exactly 4 cycles after the frame_done_in sample cycle.
- FIFO: first-word-fall-through, registered outputs. m_data/m_hcount/m_vcount/m_sof/m_eol are stable while m_valid & !m_ready. The FIFO never overflows under the issue rule.
- Scaling: m_data = min(255, ssd_dout_in << SCALE_SHIFT). Computed in 8+SCALE_SHIFT bits, then saturated.
- m_sof is high on the (0,0) beat only; m_eol is high on every x = H_PIXELS-1 beat.
- Total accepted beats per frame: exactly H_PIXELS*V_PIXELS (76800 at defaults).
- frame_done_in while in READ/DRAIN: ignored for sequencing; overrun_out pulses the next cycle.
- frame_done_in in the same cycle that DRAIN exits to IDLE: treated as overrun, not restarted.
- Reset mid-frame: all of the following clear immediately:
  - the readout aborts;
  - reading_out drops asynchronously;
  - FIFO and pipeline contents are discarded.
- The next frame_done_in after reset restarts at address 0.

Test Plan:
- BRAM model (2-cycle latency) preloaded with addr mod 256; m_ready=1; pulse frame_done_in -> m_valid first rises 4 cycles later with data 0, hcount 0, vcount 0, m_sof=1; 76800 consecutive beats, beat n = n mod 256; m_eol every 240th beat; frame_done_out one cycle after last beat; reading_out low afterwards.
- m_ready held 0 after start -> exactly FIFO_DEPTH reads issued, ssd_addr_out then frozen at 4. Release m_ready -> no gap, no duplicate, no lost beat.
- Random m_ready at 50% -> scoreboard matches full raster order and data; m_* stable while stalled.
- SCALE_SHIFT=2, BRAM values 63, 64, 100 -> m_data 252, 255, 255.
- frame_done_in pulsed mid-READ and again on the DRAIN exit cycle -> overrun_out pulses twice; frame completes once with 76800 beats; state returns to IDLE with no second frame.
- sys_rst asserted at beat 1000 -> all outputs 0 within the same cycle. Fresh frame_done_in -> readout restarts at ssd_addr_out=0 with m_sof=1.
